alu_seq: RTL and testbench

Parametrised, registered successor to the combinational 64-bit ALU. Accepts one operation per handshake on a valid/ready input port, computes single-cycle ops in one clock and multiply over WIDTH clocks with an internal state machine, and holds result plus status flags in a one-deep output register until the consumer takes it. Sits between operand fetch and writeback in the datapath.

---
 rtl/alu_seq.sv | 136 +++++++++++++
 tb/tb_alu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake and iterative multiply
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       fsel,
    input  logic             carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fout,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;
    localparam logic [4:0] OP_MUL = 5'b10010;

    logic [0:0]         state;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;

    logic               accept, mul_last;
    logic [WIDTH-1:0]   r, ax, ay;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     shamt;
    logic               c, v, ill, acin, use_add;

    assign in_ready = !rst && state == S_IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_last = state == S_MUL && cnt == SHW'(WIDTH - 1);
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign shamt    = B[SHW-1:0];
    assign sum      = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};

    // Subtracts are folded into the adder as x + ~y + 1 so carry-out is the no-borrow flag.
    always_comb begin
        r       = '0;
        c       = 1'b0;
        v       = 1'b0;
        ill     = 1'b0;
        ax      = A;
        ay      = '0;
        acin    = 1'b0;
        use_add = 1'b0;
        case (fsel)
            5'b00000: r = ~A;
            5'b00001: r = ~B;
            5'b00010: begin ay = B; use_add = 1'b1; end
            5'b00011: begin ay = B; acin = carry; use_add = 1'b1; end
            5'b00100: begin ay = WIDTH'(1); use_add = 1'b1; end
            5'b00101: begin ax = B; ay = ~A; acin = 1'b1; use_add = 1'b1; end
            5'b00110: begin ay = ~B; acin = 1'b1; use_add = 1'b1; end
            5'b00111: begin ay = ~WIDTH'(1); acin = 1'b1; use_add = 1'b1; end
            5'b01000: r = '0;
            5'b01001: r = A;
            5'b01010: r = A & B;
            5'b01011: r = A | B;
            5'b01100: r = A ^ B;
            5'b01101: begin r = A << 1; c = A[WIDTH-1]; end
            5'b01110: begin r = A >> 1; c = A[0]; end
            // The extra guard bit catches the last bit shifted out, and stays 0 for amount 0.
            5'b01111: {c, r} = {1'b0, A} << shamt;
            5'b10000: {r, c} = {A, 1'b0} >> shamt;
            5'b10001: {r, c} = $signed({A, 1'b0}) >>> shamt;
            5'b10010: r = '0;
            5'b10011: r = WIDTH'($signed(A) < $signed(B));
            default:  ill = 1'b1;
        endcase
        if (use_add) begin
            r = sum[WIDTH-1:0];
            c = sum[WIDTH];
            v = (ax[WIDTH-1] == ay[WIDTH-1]) && (sum[WIDTH-1] != ax[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            out_valid <= 1'b0;
            fout      <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (accept && fsel == OP_MUL) begin
                state  <= S_MUL;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
            end else if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= mul_last ? '0 : cnt + SHW'(1);
                if (mul_last) state <= S_IDLE;
            end

            if (accept && fsel != OP_MUL) begin
                out_valid <= 1'b1;
                fout      <= r;
                flag_z    <= (r == '0);
                flag_n    <= r[WIDTH-1];
                flag_c    <= c;
                flag_v    <= v;
                illegal   <= ill;
            end else if (mul_last) begin
                out_valid <= 1'b1;
                fout      <= acc_next[WIDTH-1:0];
                flag_z    <= (acc_next[WIDTH-1:0] == '0);
                flag_n    <= acc_next[WIDTH-1];
                flag_c    <= |acc_next[2*WIDTH-1:WIDTH];
                flag_v    <= 1'b0;
                illegal   <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH 64 and 8
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv64, ir64, ov64, or64, c64, z64, n64, cf64, v64, il64;
    logic [63:0] a64, b64, fo64;
    logic [4:0]  f64;

    logic        iv8, ir8, ov8, or8, c8, z8, n8, cf8, v8, il8;
    logic [7:0]  a8, b8, fo8;
    logic [4:0]  f8;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
        .fsel(f64), .carry(c64), .out_valid(ov64), .out_ready(or64), .fout(fo64),
        .flag_z(z64), .flag_n(n64), .flag_c(cf64), .flag_v(v64), .illegal(il64)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .fsel(f8), .carry(c8), .out_valid(ov8), .out_ready(or8), .fout(fo8),
        .flag_z(z8), .flag_n(n8), .flag_c(cf8), .flag_v(v8), .illegal(il8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {illegal, z, n, c, v}
    task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] f, input logic cin,
                        input logic [63:0] ef, input logic [4:0] efl);
        a64 = a; b64 = b; f64 = f; c64 = cin; iv64 = 1'b1;
        step();
        iv64 = 1'b0;
        chk({tag, "_valid"}, 64'(ov64), 64'd1);
        chk({tag, "_fout"}, fo64, ef);
        chk({tag, "_flags"}, 64'({il64, z64, n64, cf64, v64}), 64'(efl));
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] f, input logic cin,
                       input logic [7:0] ef, input logic [4:0] efl);
        a8 = a; b8 = b; f8 = f; c8 = cin; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        chk({tag, "_valid"}, 64'(ov8), 64'd1);
        chk({tag, "_fout"}, 64'(fo8), 64'(ef));
        chk({tag, "_flags"}, 64'({il8, z8, n8, cf8, v8}), 64'(efl));
    endtask

    task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ef, input logic [4:0] efl);
        a8 = a; b8 = b; f8 = 5'b10010; iv8 = 1'b1;
        chk({tag, "_ready_at_accept"}, 64'(ir8), 64'd1);
        step();
        iv8 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; f8 = 5'b00000;
        for (int i = 1; i <= 7; i++) begin
            chk({tag, "_busy_ready"}, 64'(ir8), 64'd0);
            chk({tag, "_busy_valid"}, 64'(ov8), 64'd0);
            step();
        end
        chk({tag, "_last_ready"}, 64'(ir8), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(ov8), 64'd1);
        chk({tag, "_fout"}, 64'(fo8), 64'(ef));
        chk({tag, "_flags"}, 64'({il8, z8, n8, cf8, v8}), 64'(efl));
        chk({tag, "_ready_after"}, 64'(ir8), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        iv64 = 0; or64 = 1; a64 = 0; b64 = 0; f64 = 0; c64 = 0;
        iv8 = 0;  or8 = 1;  a8 = 0;  b8 = 0;  f8 = 0;  c8 = 0;
        step();
        step();
        chk("rst_ready64", 64'(ir64), 64'd0);
        chk("rst_ready8", 64'(ir8), 64'd0);
        chk("rst_valid8", 64'(ov8), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready64", 64'(ir64), 64'd1);

        // Mid-stream reset with a held result
        or8 = 1'b0;
        op8("held", 8'h21, 8'h10, 5'b00010, 1'b0, 8'h31, 5'b00000);
        rst = 1'b1;
        step();
        step();
        chk("mid_rst_valid", 64'(ov8), 64'd0);
        chk("mid_rst_fout", 64'(fo8), 64'd0);
        chk("mid_rst_flags", 64'({il8, z8, n8, cf8, v8}), 64'd0);
        chk("mid_rst_ready", 64'(ir8), 64'd0);
        rst = 1'b0;
        or8 = 1'b1;
        step();
        chk("mid_rst_ready_after", 64'(ir8), 64'd1);

        op64("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b00010, 1'b0, 64'd0, 5'b01010);
        op64("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 5'b00110, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 5'b00011);
        op64("adc", 64'd5, 64'd7, 5'b00011, 1'b1, 64'd13, 5'b00000);
        op64("b_minus_a", 64'd2, 64'd1, 5'b00101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00100);

        op8("shl3", 8'h96, 8'h03, 5'b01111, 1'b0, 8'hB0, 5'b00100);
        op8("shl4", 8'h96, 8'h04, 5'b01111, 1'b0, 8'h60, 5'b00010);
        op8("shr3", 8'h96, 8'h03, 5'b10000, 1'b0, 8'h12, 5'b00010);
        op8("sra3", 8'h96, 8'h03, 5'b10001, 1'b0, 8'hF2, 5'b00110);
        op8("shl0", 8'h96, 8'h00, 5'b01111, 1'b0, 8'h96, 5'b00100);
        op8("shr0", 8'h96, 8'h00, 5'b10000, 1'b0, 8'h96, 5'b00100);
        op8("sra0", 8'h96, 8'h00, 5'b10001, 1'b0, 8'h96, 5'b00100);
        op8("slt_true", 8'h80, 8'h01, 5'b10011, 1'b0, 8'h01, 5'b00000);
        op8("slt_false", 8'h05, 8'hFF, 5'b10011, 1'b0, 8'h00, 5'b01000);
        op8("inc_ovf", 8'h7F, 8'h00, 5'b00100, 1'b0, 8'h80, 5'b00101);
        op8("dec_zero", 8'h00, 8'h00, 5'b00111, 1'b0, 8'hFF, 5'b00100);
        op8("dec_ovf", 8'h80, 8'h00, 5'b00111, 1'b0, 8'h7F, 5'b00011);
        op8("shl1", 8'h81, 8'h00, 5'b01101, 1'b0, 8'h02, 5'b00010);
        op8("shr1", 8'h81, 8'h00, 5'b01110, 1'b0, 8'h40, 5'b00010);
        op8("adc_wrap", 8'hFF, 8'h00, 5'b00011, 1'b1, 8'h00, 5'b01010);
        op8("illegal", 8'h05, 8'h03, 5'b11000, 1'b0, 8'h00, 5'b11000);
        op8("and_after_ill", 8'hF0, 8'h3C, 5'b01010, 1'b0, 8'h30, 5'b00000);

        mul8("mul_a", 8'h10, 8'h11, 8'h10, 5'b00010);
        mul8("mul_b", 8'h0D, 8'h0B, 8'h8F, 5'b00100);
        mul8("mul_c", 8'hFF, 8'hFF, 8'h01, 5'b00010);

        // Reset lands on cycle 4 of a multiply
        a8 = 8'h10; b8 = 8'h11; f8 = 5'b10010; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mul_abort_valid", 64'(ov8), 64'd0);
            step();
        end
        chk("mul_abort_ready", 64'(ir8), 64'd1);

        // Backpressure: three increments with out_ready low for four cycles
        or8 = 1'b0;
        a8 = 8'd1; f8 = 5'b00100; iv8 = 1'b1;
        step();
        chk("bp_first", 64'(fo8), 64'd2);
        chk("bp_first_ready", 64'(ir8), 64'd0);
        a8 = 8'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_fout", 64'(fo8), 64'd2);
            chk("bp_hold_valid", 64'(ov8), 64'd1);
            chk("bp_hold_ready", 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(ir8), 64'd1);
        step();
        chk("bp_second", 64'(fo8), 64'd3);
        chk("bp_second_valid", 64'(ov8), 64'd1);
        a8 = 8'd3;
        step();
        chk("bp_third", 64'(fo8), 64'd4);
        chk("bp_third_valid", 64'(ov8), 64'd1);
        iv8 = 1'b0;
        step();
        chk("bp_drained", 64'(ov8), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
